// File: rtl/cla_pipe_adder_if.sv
// rtl/cla_pipe_adder_if.sv - operand/result handshake bundle for cla_pipe_adder
interface cla_pipe_adder_if #(
  parameter int WIDTH = 16
);
  logic [WIDTH-1:0] ain;
  logic [WIDTH-1:0] bin;
  logic             cin;
  logic             sub;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  logic             out_valid;
  logic             out_ready;

  modport master (
    output ain, bin, cin, sub, in_valid, out_ready,
    input  in_ready, sum, cout, ovf, out_valid
  );

  modport slave (
    input  ain, bin, cin, sub, in_valid, out_ready,
    output in_ready, sum, cout, ovf, out_valid
  );
endinterface

// File: rtl/cla_pipe_adder.sv
// rtl/cla_pipe_adder.sv - pipelined add/sub, one 4-bit CLA group per stage; CLA_SAT_EN adds a saturating sat port
module cla_pipe_adder #(
  parameter int WIDTH = 16
) (
  input  logic clk,
  input  logic rst_n,
`ifdef CLA_SAT_EN
  input  logic sat,
`endif
  cla_pipe_adder_if.slave bus
);
  localparam int NG = WIDTH / 4;

  function automatic logic [4:0] cla4(input logic [3:0] a, input logic [3:0] b, input logic c0);
    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;
    g    = a & b;
    p    = a | b;
    c[0] = c0;
    c[1] = g[0] | (p[0] & c0);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c0);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & c0);
    return {c[4], a ^ b ^ c[3:0]};
  endfunction

  logic [NG-1:0]    v;
  logic [NG-1:0]    ld;
  logic [WIDTH-1:0] b_eff;
  logic             ovf_q;

  assign b_eff = bus.sub ? ~bus.bin : bus.bin;

  // ld[k]: stage k may load this edge; true if any stage at or after k is empty or the sink is ready.
  always_comb begin
    logic r;
    r  = bus.out_ready;
    ld = '0;
    for (int k = NG - 1; k >= 0; k--) begin
      r     = !v[k] || r;
      ld[k] = r;
    end
  end

  for (genvar k = 0; k < NG; k++) begin : g_stage
    localparam int IW = WIDTH - 4 * k;
    logic [IW-1:0]  in_a;
    logic [IW-1:0]  in_b;
    logic           in_c;
    logic           in_v;
    logic [3:0]     s;
    logic           c4;
    logic [4*k+3:0] raw;
    logic [4*k+3:0] acc_n;
    logic [4*k+3:0] acc_q;
    logic           c_q;
    logic           v_q;
`ifdef CLA_SAT_EN
    logic           in_sat;
`endif

    if (k == 0) begin : g_src
      assign in_a = bus.ain;
      assign in_b = b_eff;
      assign in_c = bus.sub | bus.cin;
      assign in_v = bus.in_valid;
      assign raw  = s;
`ifdef CLA_SAT_EN
      assign in_sat = sat;
`endif
    end else begin : g_src
      assign in_a = g_stage[k-1].g_ops.a_q;
      assign in_b = g_stage[k-1].g_ops.b_q;
      assign in_c = g_stage[k-1].c_q;
      assign in_v = g_stage[k-1].v_q;
      assign raw  = {s, g_stage[k-1].acc_q};
`ifdef CLA_SAT_EN
      assign in_sat = g_stage[k-1].g_ops.sat_q;
`endif
    end

    assign {c4, s} = cla4(in_a[3:0], in_b[3:0], in_c);

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        v_q   <= 1'b0;
        c_q   <= 1'b0;
        acc_q <= '0;
      end else if (ld[k]) begin
        v_q   <= in_v;
        c_q   <= c4;
        acc_q <= acc_n;
      end
    end

    assign v[k] = v_q;

    // Operand bits not yet consumed move down with the operation, already shifted to [3:0].
    if (k < NG - 1) begin : g_ops
      logic [IW-5:0] a_q;
      logic [IW-5:0] b_q;
`ifdef CLA_SAT_EN
      logic          sat_q;
`endif
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          a_q <= '0;
          b_q <= '0;
`ifdef CLA_SAT_EN
          sat_q <= 1'b0;
`endif
        end else if (ld[k]) begin
          a_q <= in_a[IW-1:4];
          b_q <= in_b[IW-1:4];
`ifdef CLA_SAT_EN
          sat_q <= in_sat;
`endif
        end
      end
    end

    if (k == NG - 1) begin : g_out
      logic ovf_n;
      // a^b^s at the top bit recovers the carry into bit WIDTH-1.
      assign ovf_n = in_a[3] ^ in_b[3] ^ s[3] ^ c4;

      always_comb begin
        acc_n = raw;
`ifdef CLA_SAT_EN
        if (in_sat && ovf_n) begin
          acc_n = c4 ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end
`endif
      end

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          ovf_q <= 1'b0;
        end else if (ld[k]) begin
          ovf_q <= ovf_n;
        end
      end
    end else begin : g_out
      assign acc_n = raw;
    end
  end

  assign bus.in_ready  = rst_n & ld[0];
  assign bus.out_valid = v[NG-1];
  assign bus.sum       = g_stage[NG-1].acc_q;
  assign bus.cout      = g_stage[NG-1].c_q;
  assign bus.ovf       = ovf_q;
endmodule
